// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I multi-cycle control path.
//   - opcode constants (instr[6:0])
//   - controller state encoding
//   - alu_op / wb_sel / pc_src select encodings
//   - op_class_t: one-hot instruction class from the opcode decoder
package rv32i_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   localparam logic [1:0] ALU_ADD  = 2'b00;
   localparam logic [1:0] ALU_BR   = 2'b01;
   localparam logic [1:0] ALU_FUNC = 2'b10;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;
   localparam logic [1:0] WB_IMM = 2'b11;

   localparam logic [1:0] PC_PLUS4  = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_JALR   = 2'b10;

   typedef struct packed {
      logic r;
      logic imm;
      logic load;
      logic store;
      logic branch;
      logic jal;
      logic jalr;
      logic lui;
      logic auipc;
   } op_class_t;

endpackage

// File: rtl/rv32i_opcode_decode.sv
// Combinational opcode classifier.
//   opcode : in  instr[6:0]
//   cls    : out one-hot instruction class (all zero when illegal)
//   legal  : out opcode is one of the nine supported RV32I major opcodes
module rv32i_opcode_decode
   import rv32i_pkg::*;
(
   input  logic [6:0] opcode,
   output op_class_t  cls,
   output logic       legal
);

   always_comb begin
      cls = '0;
      case (opcode)
         OP_R:      cls.r      = 1'b1;
         OP_IMM:    cls.imm    = 1'b1;
         OP_LOAD:   cls.load   = 1'b1;
         OP_STORE:  cls.store  = 1'b1;
         OP_BRANCH: cls.branch = 1'b1;
         OP_JAL:    cls.jal    = 1'b1;
         OP_JALR:   cls.jalr   = 1'b1;
         OP_LUI:    cls.lui    = 1'b1;
         OP_AUIPC:  cls.auipc  = 1'b1;
         default:   cls        = '0;
      endcase
   end

   assign legal = |cls;

endmodule

// File: rtl/rv32i_multicycle_control.sv
// Multi-cycle control FSM for the RV32I core.
// Sequences FETCH -> DECODE -> EXEC -> [MEM] -> [WB] over one shared memory
// port and drives the datapath selects. Counts cycles and retired
// instructions, and traps (sticky until reset) on an illegal opcode or a
// memory handshake that waits MEM_TIMEOUT cycles (0 disables the timeout).
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   instr, branch_taken        IR contents, branch compare result (EXEC)
//   mem_ready                  memory completes the current access
//   mem_req, mem_we, addr_sel  memory port control
//   ir_write                   latch read data into IR
//   imm_opcode                 instr[6:0] to immediate generator
//   alu_src_a/b, alu_op        ALU operand and operation selects
//   reg_write, wb_sel          register-file write strobe and source
//   pc_write, pc_src           PC update strobe and source
//   trap, state_out            fault flag, current state (debug)
//   cycle_count, instret_count free-running counters
module rv32i_multicycle_control
   import rv32i_pkg::*;
#(
   parameter int COUNT_W     = 32,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [31:0]        instr,
   input  logic               branch_taken,
   input  logic               mem_ready,
   output logic               mem_req,
   output logic               mem_we,
   output logic               addr_sel,
   output logic               ir_write,
   output logic [6:0]         imm_opcode,
   output logic               alu_src_a,
   output logic               alu_src_b,
   output logic [1:0]         alu_op,
   output logic               reg_write,
   output logic [1:0]         wb_sel,
   output logic               pc_write,
   output logic [1:0]         pc_src,
   output logic               trap,
   output logic [2:0]         state_out,
   output logic [COUNT_W-1:0] cycle_count,
   output logic [COUNT_W-1:0] instret_count
);

   localparam logic [31:0] TIMEOUT = 32'(MEM_TIMEOUT);

   state_t     state, next;
   op_class_t  cls;
   logic       legal;
   logic [31:0] wait_cnt;
   logic       waiting;
   logic       timeout_hit;
   logic       unused_instr;

   assign unused_instr = ^instr[31:7];

   rv32i_opcode_decode u_dec (
      .opcode (instr[6:0]),
      .cls    (cls),
      .legal  (legal)
   );

   assign imm_opcode = instr[6:0];
   assign state_out  = state;
   assign trap       = (state == S_TRAP);

   // Only FETCH and MEM talk to memory, so they are the only waiting states.
   assign waiting     = ((state == S_FETCH) || (state == S_MEM)) && !mem_ready;
   // Trap on the cycle the counter would reach the limit, so exactly
   // MEM_TIMEOUT unanswered cycles are tolerated before TRAP.
   assign timeout_hit = (MEM_TIMEOUT != 0) && waiting && ((wait_cnt + 32'd1) == TIMEOUT);

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_FETCH;
         wait_cnt      <= '0;
         cycle_count   <= '0;
         instret_count <= '0;
      end else begin
         state       <= next;
         cycle_count <= cycle_count + COUNT_W'(1);
         if (pc_write)
            instret_count <= instret_count + COUNT_W'(1);
         if ((next != state) && ((next == S_FETCH) || (next == S_MEM)))
            wait_cnt <= '0;
         else if (waiting)
            wait_cnt <= wait_cnt + 32'd1;
      end
   end

   always_comb begin
      next      = state;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      addr_sel  = 1'b0;
      ir_write  = 1'b0;
      alu_src_a = 1'b0;
      alu_src_b = 1'b0;
      alu_op    = ALU_ADD;
      reg_write = 1'b0;
      wb_sel    = WB_ALU;
      pc_write  = 1'b0;
      pc_src    = PC_PLUS4;

      case (state)
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_write = 1'b1;
               next     = S_DECODE;
            end
         end
         S_DECODE: next = legal ? S_EXEC : S_TRAP;
         S_EXEC: begin
            next = S_WB;
            if (cls.r) begin
               alu_op = ALU_FUNC;
            end else if (cls.imm) begin
               alu_src_b = 1'b1;
               alu_op    = ALU_FUNC;
            end else if (cls.load || cls.store) begin
               alu_src_b = 1'b1;
               next      = S_MEM;
            end else if (cls.auipc) begin
               alu_src_a = 1'b1;
               alu_src_b = 1'b1;
            end else if (cls.branch) begin
               alu_op   = ALU_BR;
               pc_write = 1'b1;
               pc_src   = branch_taken ? PC_BRANCH : PC_PLUS4;
               next     = S_FETCH;
            end
         end
         S_MEM: begin
            mem_req  = 1'b1;
            addr_sel = 1'b1;
            mem_we   = cls.store;
            if (mem_ready) begin
               if (cls.store) begin
                  pc_write = 1'b1;
                  next     = S_FETCH;
               end else begin
                  next = S_WB;
               end
            end
         end
         S_WB: begin
            reg_write = 1'b1;
            pc_write  = 1'b1;
            next      = S_FETCH;
            if (cls.load)                 wb_sel = WB_MEM;
            else if (cls.jal || cls.jalr) wb_sel = WB_PC4;
            else if (cls.lui)             wb_sel = WB_IMM;
            if (cls.jal)       pc_src = PC_BRANCH;
            else if (cls.jalr) pc_src = PC_JALR;
         end
         S_TRAP:  next = S_TRAP;
         default: next = S_TRAP;
      endcase

      if (timeout_hit)
         next = S_TRAP;

      // Reset beats any state, including a half-finished access.
      if (reset) begin
         mem_req   = 1'b0;
         mem_we    = 1'b0;
         ir_write  = 1'b0;
         reg_write = 1'b0;
         pc_write  = 1'b0;
      end
   end

endmodule

// File: tb/tb_rv32i_multicycle_control.sv
module tb_rv32i_multicycle_control;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr;
   logic        branch_taken;
   logic        mem_ready;
   logic        mem_req, mem_we, addr_sel, ir_write;
   logic [6:0]  imm_opcode;
   logic        alu_src_a, alu_src_b;
   logic [1:0]  alu_op;
   logic        reg_write;
   logic [1:0]  wb_sel;
   logic        pc_write;
   logic [1:0]  pc_src;
   logic        trap;
   logic [2:0]  state_out;
   logic [31:0] cycle_count, instret_count;

   int n_chk  = 0;
   int n_pass = 0;

   localparam logic [31:0] I_ADDI = 32'h00500093;
   localparam logic [31:0] I_LW   = 32'h0000A103;
   localparam logic [31:0] I_BEQ  = 32'h00208463;
   localparam logic [31:0] I_JALR = 32'h000080E7;
   localparam logic [31:0] I_SW   = 32'h0020A023;
   localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;

   rv32i_multicycle_control #(.COUNT_W(32), .MEM_TIMEOUT(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .instr         (instr),
      .branch_taken  (branch_taken),
      .mem_ready     (mem_ready),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .addr_sel      (addr_sel),
      .ir_write      (ir_write),
      .imm_opcode    (imm_opcode),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op        (alu_op),
      .reg_write     (reg_write),
      .wb_sel        (wb_sel),
      .pc_write      (pc_write),
      .pc_src        (pc_src),
      .trap          (trap),
      .state_out     (state_out),
      .cycle_count   (cycle_count),
      .instret_count (instret_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // FETCH with immediate ready, then DECODE; returns one step into EXEC.
   task automatic fetch_decode(input logic [31:0] i);
      instr     = i;
      mem_ready = 1'b1;
      #1;
      chk("fetch_state", 32'(state_out), 0);
      chk("fetch_irw", 32'(ir_write), 1);
      chk("imm_opcode", 32'(imm_opcode), 32'(i[6:0]));
      tick;
      mem_ready = 1'b0;
      #1;
      chk("decode_state", 32'(state_out), 1);
      tick;
   endtask

   initial begin
      reset = 1'b1; instr = '0; branch_taken = 1'b0; mem_ready = 1'b0;
      tick; tick;
      mem_ready = 1'b1;
      #1;
      chk("rst_state", 32'(state_out), 0);
      chk("rst_memreq", 32'(mem_req), 0);
      chk("rst_irw", 32'(ir_write), 0);
      chk("rst_cycles", cycle_count, 0);
      chk("rst_trap", 32'(trap), 0);

      // addi: FETCH DECODE EXEC WB
      reset = 1'b0;
      fetch_decode(I_ADDI);
      #1;
      chk("addi_exec", 32'(state_out), 2);
      chk("addi_srcb", 32'(alu_src_b), 1);
      chk("addi_aluop", 32'(alu_op), 2);
      tick; #1;
      chk("addi_wb", 32'(state_out), 4);
      chk("addi_regw", 32'(reg_write), 1);
      chk("addi_wbsel", 32'(wb_sel), 0);
      chk("addi_pcsrc", 32'(pc_src), 0);
      chk("addi_pcw", 32'(pc_write), 1);
      tick; #1;
      chk("addi_instret", instret_count, 1);
      chk("addi_cycles", cycle_count, 4);

      // lw with ready delayed 3 cycles in MEM
      fetch_decode(I_LW);
      #1;
      chk("lw_srcb", 32'(alu_src_b), 1);
      chk("lw_aluop", 32'(alu_op), 0);
      for (int k = 0; k < 3; k++) begin
         tick; #1;
         chk("lw_mem_state", 32'(state_out), 3);
         chk("lw_memreq", 32'(mem_req), 1);
         chk("lw_addrsel", 32'(addr_sel), 1);
         chk("lw_memwe", 32'(mem_we), 0);
      end
      tick;
      mem_ready = 1'b1;
      #1;
      chk("lw_mem_done", 32'(state_out), 3);
      tick;
      mem_ready = 1'b0;
      #1;
      chk("lw_wb", 32'(state_out), 4);
      chk("lw_wbsel", 32'(wb_sel), 1);
      tick; #1;
      chk("lw_cycles", cycle_count, 12);
      chk("lw_instret", instret_count, 2);

      // beq taken, then not taken
      for (int t = 1; t >= 0; t--) begin
         fetch_decode(I_BEQ);
         branch_taken = t[0];
         #1;
         chk("beq_aluop", 32'(alu_op), 1);
         chk("beq_pcw", 32'(pc_write), 1);
         chk("beq_pcsrc", 32'(pc_src), 32'(t));
         chk("beq_regw", 32'(reg_write), 0);
         tick;
         branch_taken = 1'b0;
         #1;
         chk("beq_back", 32'(state_out), 0);
      end
      chk("beq_cycles", cycle_count, 18);
      chk("beq_instret", instret_count, 4);

      // jalr
      fetch_decode(I_JALR);
      tick; #1;
      chk("jalr_wb", 32'(state_out), 4);
      chk("jalr_regw", 32'(reg_write), 1);
      chk("jalr_wbsel", 32'(wb_sel), 2);
      chk("jalr_pcsrc", 32'(pc_src), 2);
      tick;

      // sw: MEM completes immediately, no WB
      fetch_decode(I_SW);
      tick;
      mem_ready = 1'b1;
      #1;
      chk("sw_mem", 32'(state_out), 3);
      chk("sw_memwe", 32'(mem_we), 1);
      chk("sw_pcw", 32'(pc_write), 1);
      chk("sw_pcsrc", 32'(pc_src), 0);
      tick;
      mem_ready = 1'b0;
      #1;
      chk("sw_nowb", 32'(state_out), 0);
      chk("sw_instret", instret_count, 6);
      chk("sw_cycles", cycle_count, 26);

      // illegal opcode -> TRAP, held
      fetch_decode(I_BAD);
      #1;
      chk("bad_trap_state", 32'(state_out), 5);
      chk("bad_trap", 32'(trap), 1);
      chk("bad_cycles0", cycle_count, 28);
      mem_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick;
         chk("trap_hold", 32'(trap), 1);
         chk("trap_memreq", 32'(mem_req), 0);
      end
      chk("trap_pcw", 32'(pc_write), 0);
      chk("trap_cycles", cycle_count, 38);
      chk("trap_instret", instret_count, 6);
      reset = 1'b1;
      tick;
      chk("trap_rst_state", 32'(state_out), 0);
      chk("trap_rst_cycles", cycle_count, 0);
      chk("trap_rst_instret", instret_count, 0);
      chk("trap_rst_trap", 32'(trap), 0);

      // FETCH timeout with MEM_TIMEOUT=4
      reset = 1'b0; mem_ready = 1'b0; instr = I_ADDI;
      tick; tick; tick;
      chk("to_still_fetch", 32'(state_out), 0);
      tick;
      chk("to_trap", 32'(state_out), 5);
      chk("to_trap_flag", 32'(trap), 1);

      // reset in the middle of a load's MEM wait
      reset = 1'b1;
      tick;
      reset = 1'b0;
      fetch_decode(I_LW);
      tick; tick;
      chk("mid_mem_state", 32'(state_out), 3);
      reset = 1'b1;
      #1;
      chk("mid_rst_memreq", 32'(mem_req), 0);
      chk("mid_rst_pcw", 32'(pc_write), 0);
      chk("mid_rst_irw", 32'(ir_write), 0);
      tick;
      chk("mid_rst_fetch", 32'(state_out), 0);
      reset = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/rv32i_multicycle_control.md
Name: rv32i_multicycle_control

Overview:
- Multi-cycle control FSM for the RV32I core.
- Sequences instruction fetch, decode, execute, memory access and writeback over a single shared memory port.
- Drives the immediate generator's opcode select, ALU operand/op selects, register-file write, PC update and writeback mux.
- Counts cycles and retired instructions; traps on illegal opcodes or a memory handshake timeout.

Parameters:
- COUNT_W, 32, width of cycle_count and instret_count (wrap modulo 2^COUNT_W).
- MEM_TIMEOUT, 255, max cycles waiting for mem_ready in one access before trap; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- instr  in  32  current instruction register contents
- branch_taken  in  1  ALU branch-compare result, valid in EXEC
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  1 = store access, 0 = read
- addr_sel  out  1  0 = PC, 1 = ALU result
- ir_write  out  1  latch memory read data into IR
- imm_opcode  out  7  instr[6:0], to the immediate generator
- alu_src_a  out  1  0 = rs1, 1 = PC
- alu_src_b  out  1  0 = rs2, 1 = immediate
- alu_op  out  2  00 add, 01 branch compare, 10 funct3/funct7 decode
- reg_write  out  1  register-file write strobe
- wb_sel  out  2  00 ALU, 01 memory data, 10 PC+4, 11 immediate
- pc_write  out  1  PC update strobe
- pc_src  out  2  00 PC+4, 01 PC+imm, 10 (rs1+imm) & ~1
- trap  out  1  sticky fault indicator
- state_out  out  3  current state, for debug
- cycle_count  out  COUNT_W  cycles since reset
- instret_count  out  COUNT_W  retired instructions

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- Reset: state = FETCH; counters = 0; trap = 0; wait counter = 0. All strobes (mem_req, ir_write, reg_write, pc_write, mem_we) are 0 in any cycle with reset high. Reset overrides every state, including mid-access and TRAP.
- Outputs are combinational from state and instr[6:0]. imm_opcode = instr[6:0] in all states.
- FETCH:
  - mem_req=1, addr_sel=0.
  - If mem_ready: ir_write=1, next state DECODE. Otherwise stay.
- DECODE: legal opcodes are 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111. Illegal opcode -> TRAP; legal -> EXEC.
- EXEC, by opcode:
  - R: alu_src_b=0, alu_op=10.
  - I-ALU: alu_src_b=1, alu_op=10.
  - Load/store: alu_src_b=1, alu_op=00, next MEM.
  - AUIPC: alu_src_a=1, alu_src_b=1, alu_op=00.
  - LUI: no ALU use.
  - Branch: alu_op=01, pc_write=1, pc_src = branch_taken ? 01 : 00, next FETCH.
  - All other opcodes: next WB.
- MEM:
  - mem_req=1, addr_sel=1, mem_we = (store).
  - Wait for mem_ready.
  - Store: pc_write=1, pc_src=00, next FETCH.
  - Load: next WB.
- WB:
  - reg_write=1, pc_write=1, next FETCH.
  - wb_sel: 01 load, 10 JAL/JALR, 11 LUI, 00 otherwise.
  - pc_src: 01 JAL, 10 JALR, 00 otherwise.
- pc_write is asserted exactly once per legal instruction. instret_count increments on every pc_write.
- cycle_count increments every non-reset cycle, including TRAP.
- Timeout: wait counter clears on entering FETCH or MEM and increments each cycle mem_req=1 and mem_ready=0. If MEM_TIMEOUT != 0 and the counter reaches MEM_TIMEOUT, next state is TRAP.
- mem_ready outside FETCH/MEM is ignored.
- TRAP: trap=1, all strobes 0, held until reset.

Decomposition:
- Shared package rv32i_pkg: opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC), state encodings, alu_op / wb_sel / pc_src encodings.
- Sub-module rv32i_opcode_decode: combinational; instr[6:0] -> one-hot class plus legal flag.

Test Plan:
- addi (0x00500093), mem_ready on first FETCH cycle: FETCH->DECODE->EXEC->WB in 4 cycles; WB has reg_write=1, wb_sel=00, pc_src=00; instret_count=1.
- lw (0x0000A103), mem_ready delayed 3 cycles in MEM: mem_req=1, addr_sel=1, mem_we=0 held through the wait; WB wb_sel=01; 8 cycles total.
- beq with branch_taken=1, then again with 0: EXEC pc_write=1 with pc_src=01, then 00; reg_write never asserted; 3 cycles each.
- jalr (0x000080E7): WB asserts reg_write=1, wb_sel=10, pc_src=10; sw (0x0020A023): MEM mem_we=1, no WB state.
- instr=0xFFFFFFFF: TRAP after DECODE; trap=1 persists 10 cycles; cycle_count keeps counting, instret_count frozen; reset returns to FETCH with counters 0.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH: TRAP after 4 wait cycles; reset asserted mid-MEM instead: next state FETCH, strobes 0 in the reset cycle.
